hc_sr_echo_mc: RTL
==================

# hc_sr_echo_mc

Multi-channel ultrasonic ranging controller, the parametrised successor of the single-channel echo timer. It time-multiplexes up to CH_NUM HC-SR04-type sensors round-robin, so only one sensor fires at a time and there is no acoustic crosstalk. For each channel it generates the trigger pulse, times the echo in 1 µs ticks derived from the system clock, detects timeouts, and emits one tagged distance result per channel. It sits between the sensor I/O pins and the display/UART formatting logic.

## Interface
- CH_NUM, 4: number of sensor channels (1..8).
- CLK_FREQ, 50_000_000: Clk frequency in Hz; must be a multiple of 1_000_000.
- TRIG_US, 10: trigger pulse width in µs.
- T_MAX, 60_000: timeout in µs for both the echo-rise wait and the echo-high time.
- GAP_US, 10_000: idle time in µs after each channel's result, before the next trigger.
- CNT_W, 16: µs counter width; must satisfy 2^CNT_W > max(T_MAX, GAP_US).
- DIST_W, CNT_W+5: distance output width.
- Clk, input, 1: system clock; the only clock in the block.
- Rst, input, 1: asynchronous, active-high reset.
- en, input, 1: enables measurement scheduling.
- echo, input, CH_NUM: raw echo pins, asynchronous to Clk.
- trig_o, output, CH_NUM: trigger pins; at most one bit high at any time.
- dist_o, output, DIST_W: distance in units of 10 µm (cnt×17).
- ch_o, output, $clog2(CH_NUM) (min 1): channel index of the current result.
- valid_o, output, 1: one-cycle result strobe; there is no backpressure.
- timeout_o, output, 1: qualifies valid_o; high means no valid echo.
- busy_o, output, 1: high whenever the FSM is not in IDLE.

## Operation
- Echo conditioning: each bit passes through a 2-FF synchronizer, then an edge detector on the synced level (rise = cur & ~prev, fall = ~cur & prev).
- µs tick: a prescaler produces a one-cycle tick every CLK_FREQ/1_000_000 clocks. It restarts on every state entry, so state durations are exact.
- FSM states:
  - IDLE: wait for en=1. Exit to TRIG with ch = current pointer.
  - TRIG: trig_o[ch]=1 for TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: wait for a synced rise on echo[ch]. On rise, clear the counter and go to MEAS. If T_MAX ticks elapse first, issue a timeout result and go to GAP. A level already high on entry is not a rise; a stuck-high echo ends in timeout.
  - MEAS: increment cnt on each tick. On synced fall, issue dist_o = (cnt<<4)+cnt and timeout_o=0. If cnt reaches T_MAX-1 before the fall, issue a timeout result. Either way, go to GAP.
  - GAP: wait GAP_US ticks. Advance the channel pointer (CH_NUM-1 wraps to 0). Go to TRIG if en=1, else IDLE.
- Timeout result: dist_o = all ones, timeout_o=1, valid_o=1, ch_o = ch.
- en=0 mid-sequence does not abort; the current channel completes through GAP, then the FSM returns to IDLE.
- Echo activity on non-selected channels is ignored.
- Arithmetic: the product is computed at DIST_W bits with no truncation; max (T_MAX-1)×17 = 1_019_983 fits in 21 bits.

## Timing
- Reset values: trig_o=0, dist_o=0, ch_o=0, valid_o=0, timeout_o=0, busy_o=0; FSM in IDLE; channel pointer 0. Reset asserted mid-operation drops trig_o in the same instant (asynchronous).
- en=1 in IDLE: trig_o[0] rises on the next Clk edge and stays high exactly TRIG_US×CLK_FREQ/1e6 clocks.
- Echo fall at a pin → valid_o high 3 clocks later (2 sync + 1 result register). Add 3 clocks when HC_SR_DEGLITCH_EN is defined.
- dist_o, ch_o and timeout_o are updated with valid_o and held until the next result.
- Counter quantisation: ±1 µs (±17 units).

## Configuration
- HC_SR_DEGLITCH_EN defined: after synchronization, each echo bit changes its filtered level only after 4 consecutive equal samples. Pulses shorter than 4 clocks are rejected. Latency +3 clocks.
- Not defined: the 2-FF synced level feeds the edge detector directly.

## Structure
- Package hc_sr_pkg holds the FSM state typedef (IDLE, TRIG, WAIT_RISE, MEAS, GAP), the DIST_MULT=17 constant and US_PER_S=1_000_000.
- Sub-module hc_sr_us_tick: prescaler with a sync restart input and a one-cycle tick output, parametrised by CLK_FREQ.
- Synchronizer, deglitch and edge detection are generate loops inside the top module.

## Test plan
- CH_NUM=2, en=1; ch0 echo high 1000 µs, 200 µs after trig falls → valid_o with ch_o=0, dist_o=17000, timeout_o=0; trig_o[0] width = 500 clocks.
- Echo never rises on ch1 → after 60_000 µs in WAIT_RISE: valid_o, ch_o=1, timeout_o=1, dist_o all ones.
- Echo held high 70_000 µs → timeout result when cnt=59_999; no second result on the late fall.
- en held 1 for three cycles → result order ch0, ch1, ch0; never two trig_o bits high; GAP of 10_000 µs between each result and the next trigger.
- Rst pulsed mid-MEAS → all outputs 0 immediately; after release with en=1, the next trigger is on ch0.
- HC_SR_DEGLITCH_EN defined: 2-clock high glitch on echo during WAIT_RISE → no MEAS entry. Without the macro, the same glitch → result dist_o=0 or 17.

Source files
------------

// File: rtl/hc_sr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hc_sr_pkg
// Purpose  : Shared types and constants for the multi-channel ultrasonic
//            ranging controller (hc_sr_echo_mc and its sub-modules).
// Contents : state_t    - controller FSM states
//            DIST_MULT  - distance scale: 1 us of echo = 17 units of 10 um
//            US_PER_S   - microseconds per second, used for the prescaler
// Revision : 1.0 - initial release
// ============================================================================
package hc_sr_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEAS      = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Speed of sound ~340 m/s, round trip: 170 m/s = 17 units of 10 um per us.
  localparam int DIST_MULT = 17;
  localparam int US_PER_S  = 1_000_000;

endpackage
`default_nettype wire

// File: rtl/hc_sr_us_tick.sv
`default_nettype none
// ============================================================================
// Module   : hc_sr_us_tick
// Purpose  : Microsecond prescaler. Emits a one-cycle tick every
//            CLK_FREQ/US_PER_S clocks. A synchronous restart marks the first
//            cycle of a new interval, so the n-th tick after a restart lands
//            exactly n*DIV-1 cycles later and n ticks span n*DIV clocks.
// Ports    : Clk     - system clock
//            Rst     - asynchronous active-high reset
//            restart - high in the first cycle of a new interval
//            tick    - one-cycle microsecond strobe
// Revision : 1.0 - initial release
// ============================================================================
module hc_sr_us_tick
  import hc_sr_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_FREQ / US_PER_S;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV <= 1) begin : g_div1
      // One tick per clock: every cycle, including the restart cycle, is a us.
      logic unused_inputs;
      assign unused_inputs = ^{Clk, Rst, restart};
      assign tick = 1'b1;
    end else begin : g_divn
      logic [PW-1:0] cnt;

      // The restart cycle is cycle 0 of the interval, so load 1 for the next.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          cnt <= '0;
        end else if (restart) begin
          cnt <= PW'(1);
        end else if (cnt == PW'(DIV - 1)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + PW'(1);
        end
      end

      assign tick = ~restart & (cnt == PW'(DIV - 1));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hc_sr_echo_mc.sv
`default_nettype none
// ============================================================================
// Module   : hc_sr_echo_mc
// Purpose  : Round-robin controller for CH_NUM HC-SR04-type sensors. Fires one
//            trigger at a time, times the echo in 1 us ticks, flags timeouts
//            and emits one tagged distance result per channel.
// Ports    : Clk, Rst  - clock, asynchronous active-high reset
//            en        - enables measurement scheduling
//            echo      - raw echo pins (asynchronous)
//            trig_o    - trigger pins, at most one high
//            dist_o    - distance in 10 um units (all ones on timeout)
//            ch_o      - channel of the current result
//            valid_o   - one-cycle result strobe
//            timeout_o - result carries no valid echo
//            busy_o    - FSM is not idle
// Config   : HC_SR_DEGLITCH_EN - when defined, each synced echo bit must hold
//            4 consecutive equal samples before its level changes (+3 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module hc_sr_echo_mc
  import hc_sr_pkg::*;
#(
  parameter  int CH_NUM   = 4,
  parameter  int CLK_FREQ = 50_000_000,
  parameter  int TRIG_US  = 10,
  parameter  int T_MAX    = 60_000,
  parameter  int GAP_US   = 10_000,
  parameter  int CNT_W    = 16,
  parameter  int DIST_W   = CNT_W + 5,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic [CH_NUM-1:0] echo,
  output logic [CH_NUM-1:0] trig_o,
  output logic [DIST_W-1:0] dist_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              valid_o,
  output logic              timeout_o,
  output logic              busy_o
);

  localparam logic [CH_NUM-1:0] ONE_HOT0 = CH_NUM'(1);

  logic [CH_NUM-1:0] rise, fall;

  // Per-channel conditioning: 2-FF synchronizer, optional deglitch, edges.
  generate
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic s1, s2, lvl, prev;

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end else begin
          s1 <= echo[i];
          s2 <= s1;
        end
      end

`ifdef HC_SR_DEGLITCH_EN
      // Level follows s2 only when s2 and its last three samples agree; the
      // combinational pass keeps the added latency at 3 clocks.
      logic [2:0] hist;
      logic       held;

      assign lvl = (s2 == hist[0] && hist[0] == hist[1] && hist[1] == hist[2])
                   ? s2 : held;

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          hist <= '0;
          held <= 1'b0;
        end else begin
          hist <= {hist[1:0], s2};
          held <= lvl;
        end
      end
`else
      assign lvl = s2;
`endif

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) prev <= 1'b0;
        else     prev <= lvl;
      end

      assign rise[i] = lvl & ~prev;
      assign fall[i] = ~lvl & prev;
    end
  endgenerate

  state_t           state;
  logic [CH_W-1:0]  ptr;
  logic [CNT_W-1:0] tcnt;   // ticks spent in TRIG / WAIT_RISE / GAP
  logic [CNT_W-1:0] cnt;    // echo-high time in us
  logic             entry;  // first cycle of a newly entered state
  logic             tick;
  logic [CH_W-1:0]  nxt;

  hc_sr_us_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .Clk     (Clk),
    .Rst     (Rst),
    .restart (entry),
    .tick    (tick)
  );

  assign nxt = (ptr == CH_W'(CH_NUM - 1)) ? '0 : ptr + CH_W'(1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tcnt      <= '0;
      cnt       <= '0;
      entry     <= 1'b0;
      trig_o    <= '0;
      dist_o    <= '0;
      ch_o      <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      entry   <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state  <= TRIG;
            entry  <= 1'b1;
            tcnt   <= '0;
            trig_o <= ONE_HOT0 << ptr;
            busy_o <= 1'b1;
          end
        end
        TRIG: begin
          if (tick) begin
            if (tcnt == CNT_W'(TRIG_US - 1)) begin
              state  <= WAIT_RISE;
              entry  <= 1'b1;
              tcnt   <= '0;
              trig_o <= '0;
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        WAIT_RISE: begin
          if (rise[ptr]) begin
            state <= MEAS;
            entry <= 1'b1;
            cnt   <= '0;
          end else if (tick) begin
            if (tcnt == CNT_W'(T_MAX - 1)) begin
              dist_o    <= '1;
              timeout_o <= 1'b1;
              valid_o   <= 1'b1;
              ch_o      <= ptr;
              state     <= GAP;
              entry     <= 1'b1;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        MEAS: begin
          if (fall[ptr]) begin
            // cnt * DIST_MULT as shift-and-add, full DIST_W width.
            dist_o    <= (DIST_W'(cnt) << 4) + DIST_W'(cnt);
            timeout_o <= 1'b0;
            valid_o   <= 1'b1;
            ch_o      <= ptr;
            state     <= GAP;
            entry     <= 1'b1;
            tcnt      <= '0;
          end else if (cnt == CNT_W'(T_MAX - 1)) begin
            dist_o    <= '1;
            timeout_o <= 1'b1;
            valid_o   <= 1'b1;
            ch_o      <= ptr;
            state     <= GAP;
            entry     <= 1'b1;
            tcnt      <= '0;
          end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (tick) begin
            if (tcnt == CNT_W'(GAP_US - 1)) begin
              ptr   <= nxt;
              tcnt  <= '0;
              entry <= 1'b1;
              if (en) begin
                state  <= TRIG;
                trig_o <= ONE_HOT0 << nxt;
              end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          trig_o <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
